// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and the round-robin pick helper for rr_mux_arbiter.
package rr_mux_arbiter_pkg;

   // Arbiter has a single decision cycle (IDLE) and a burst phase (GRANT).
   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   // The pick helper works on a fixed maximum width; callers zero-extend.
   localparam int RR_MAX_N = 32;
   localparam int RR_IDX_W = 5;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] idx;
   } rr_pick_t;

   // First set request at or after ptr, wrapping at n-1 (n need not be 2^k).
   function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                        input logic [RR_IDX_W-1:0] ptr,
                                        input int                  n);
      rr_pick_t r;
      int       j;
      logic     hit;
      r.found = 1'b0;
      r.idx   = '0;
      for (int k = 0; k < RR_MAX_N; k++) begin
         j       = int'(ptr) + k;
         j       = (j >= n) ? (j - n) : j;
         hit     = (k < n) && !r.found && req[j[RR_IDX_W-1:0]];
         r.idx   = hit ? j[RR_IDX_W-1:0] : r.idx;
         r.found = r.found | hit;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux.sv
// N:1 single-bit combinational mux; out-of-range selects return 0.
module mux #(
   parameter int N   = 4,
   parameter int SEL = $clog2(N)
) (
   input  logic [N-1:0]   mux_din,
   input  logic [SEL-1:0] mux_sel,
   output logic           mux_dout
);

   // OR-reduce the selected bit so no index ever leaves the din range.
   always_comb begin
      mux_dout = 1'b0;
      for (int i = 0; i < N; i++) begin
         mux_dout = mux_dout | ((mux_sel == SEL'(i)) & mux_din[i]);
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Burst-limited round-robin owner of a shared N:1 bit channel with a
// valid/ready downstream.
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int N         = 4,
   parameter int SEL       = $clog2(N),
   parameter int MAX_BURST = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   din,
   input  logic           ready,
   output logic [N-1:0]   gnt,
   output logic [SEL-1:0] mux_sel,
   output logic           dout,
   output logic           dout_valid
);

   localparam int CW = $clog2(MAX_BURST + 1);

   arb_state_t     state_q, state_d;
   logic [SEL-1:0] owner_q, owner_d;
   logic [SEL-1:0] ptr_q, ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   rr_pick_t       pick_s;
   logic           owner_req_s;
   logic           accept_s;
   logic           release_s;
   logic [SEL-1:0] ptr_next_s;

   // Owner's request bit and the one-hot grant, without indexing past N.
   always_comb begin
      owner_req_s = 1'b0;
      for (int i = 0; i < N; i++) begin
         owner_req_s = owner_req_s | ((owner_q == SEL'(i)) & req[i]);
         gnt[i]      = (state_q == ARB_GRANT) && (owner_q == SEL'(i));
      end
   end

   // Handshake, release decision and the wrapped next-priority index.
   always_comb begin
      pick_s     = rr_pick(RR_MAX_N'(req), RR_IDX_W'(ptr_q), N);
      dout_valid = (state_q == ARB_GRANT) & owner_req_s;
      accept_s   = dout_valid & ready;
      release_s  = !owner_req_s || (accept_s && (cnt_q == CW'(MAX_BURST - 1)));
      ptr_next_s = (owner_q == SEL'(N - 1)) ? '0 : (owner_q + SEL'(1));
      mux_sel    = owner_q;
   end

   // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_s.found) begin
               owner_d = SEL'(pick_s.idx);
               cnt_d   = '0;
               state_d = ARB_GRANT;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_GRANT: begin
            if (release_s) begin
               state_d = ARB_IDLE;
               ptr_d   = ptr_next_s;
               cnt_d   = '0;
            end else if (accept_s) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; reset wins over any beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   mux #(
      .N   (N),
      .SEL (SEL)
   ) u_mux (
      .mux_din  (din),
      .mux_sel  (owner_q),
      .mux_dout (dout)
   );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: N=4/MAX_BURST=8, N=3/MAX_BURST=8 and
// N=4/MAX_BURST=1 instances exercised in turn.
module tb_rr_mux_arbiter;

   logic clk;

   logic       a_rst, a_ready, a_dout, a_valid;
   logic [3:0] a_req, a_din, a_gnt;
   logic [1:0] a_sel;

   logic       b_rst, b_ready, b_dout, b_valid;
   logic [2:0] b_req, b_din, b_gnt;
   logic [1:0] b_sel;

   logic       c_rst, c_ready, c_dout, c_valid;
   logic [3:0] c_req, c_din, c_gnt;
   logic [1:0] c_sel;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic       chk;
      logic       rst;
      logic [3:0] req;
      logic [3:0] din;
      logic       rdy;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       valid;
      logic       dout;
   } vec_t;

   vec_t tbl [15];

   rr_mux_arbiter #(.N(4), .MAX_BURST(8)) dut_a (
      .clk(clk), .rst(a_rst), .req(a_req), .din(a_din), .ready(a_ready),
      .gnt(a_gnt), .mux_sel(a_sel), .dout(a_dout), .dout_valid(a_valid));

   rr_mux_arbiter #(.N(3), .MAX_BURST(8)) dut_b (
      .clk(clk), .rst(b_rst), .req(b_req), .din(b_din), .ready(b_ready),
      .gnt(b_gnt), .mux_sel(b_sel), .dout(b_dout), .dout_valid(b_valid));

   rr_mux_arbiter #(.N(4), .MAX_BURST(1)) dut_c (
      .clk(clk), .rst(c_rst), .req(c_req), .din(c_din), .ready(c_ready),
      .gnt(c_gnt), .mux_sel(c_sel), .dout(c_dout), .dout_valid(c_valid));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [3:0] g_act, input logic [3:0] g_exp,
                        input logic [1:0] s_act, input logic [1:0] s_exp,
                        input logic v_act, input logic v_exp,
                        input logic d_act, input logic d_exp);
      n_vec++;
      if (g_act !== g_exp || s_act !== s_exp || v_act !== v_exp || d_act !== d_exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got gnt=%b sel=%0d valid=%b dout=%b, want gnt=%b sel=%0d valid=%b dout=%b",
                  name, $time, g_act, s_act, v_act, d_act, g_exp, s_exp, v_exp, d_exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic a_drive(input logic rst, input logic [3:0] req, input logic [3:0] din, input logic rdy);
      @(negedge clk);
      a_rst = rst; a_req = req; a_din = din; a_ready = rdy;
      #1;
   endtask

   task automatic b_drive(input logic rst, input logic [2:0] req, input logic [2:0] din, input logic rdy);
      @(negedge clk);
      b_rst = rst; b_req = req; b_din = din; b_ready = rdy;
      #1;
   endtask

   task automatic c_drive(input logic rst, input logic [3:0] req, input logic [3:0] din, input logic rdy);
      @(negedge clk);
      c_rst = rst; c_req = req; c_din = din; c_ready = rdy;
      #1;
   endtask

   task automatic a_chk(input string name, input logic [3:0] g, input logic [1:0] s, input logic v, input logic d);
      check(name, a_gnt, g, a_sel, s, a_valid, v, a_dout, d);
   endtask

   task automatic b_chk(input string name, input logic [2:0] g, input logic [1:0] s, input logic v, input logic d);
      check(name, {1'b0, b_gnt}, {1'b0, g}, b_sel, s, b_valid, v, b_dout, d);
   endtask

   task automatic c_chk(input string name, input logic [3:0] g, input logic [1:0] s, input logic v, input logic d);
      check(name, c_gnt, g, c_sel, s, c_valid, v, c_dout, d);
   endtask

   task automatic apply_row(input int i);
      a_drive(tbl[i].rst, tbl[i].req, tbl[i].din, tbl[i].rdy);
      if (tbl[i].chk) begin
         a_chk($sformatf("table_row%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].valid, tbl[i].dout);
      end
   endtask

   initial begin
      logic [3:0] d;
      logic [2:0] d3;
      logic       rdy;
      int         o;

      //           chk   rst   req      din      rdy   gnt      sel   valid dout
      tbl[0]  = '{1'b1, 1'b1, 4'b1111, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 4'b0101, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 4'b0101, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
      tbl[5]  = '{1'b1, 1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 4'b0101, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 4'b0001, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1};
      tbl[13] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};

      a_rst = 1'b1; a_req = 4'b1111; a_din = 4'b0000; a_ready = 1'b1;
      b_rst = 1'b1; b_req = 3'b000;  b_din = 3'b000;  b_ready = 1'b1;
      c_rst = 1'b1; c_req = 4'b0000; c_din = 4'b0000; c_ready = 1'b1;
      @(posedge clk);

      // Reset with all requests high, then first grant to requester 0.
      apply_row(0);
      apply_row(1);

      // Rotation 0,1,2,3,0: 8 beats each, one idle cycle between grants.
      for (int g = 0; g < 5; g++) begin
         o = g % 4;
         for (int b = 0; b < 8; b++) begin
            d = 4'($urandom);
            a_drive(1'b0, 4'b1111, d, 1'b1);
            a_chk("rotation_beat", 4'(1 << o), 2'(o), 1'b1, d[o]);
         end
         d = 4'($urandom);
         a_drive(1'b0, 4'b1111, d, 1'b1);
         a_chk("rotation_gap", 4'b0000, 2'(o), 1'b0, d[o]);
      end

      // Reset, early release of requester 0, skip to 2, wrap back to 0.
      for (int i = 2; i < 15; i++) begin
         apply_row(i);
      end

      // Backpressure: requester 1 stalled 5 cycles after 3 accepted beats.
      d = 4'($urandom);
      a_drive(1'b0, 4'b0010, d, 1'b1);
      a_chk("bp_arbitrate", 4'b0000, 2'd0, 1'b0, d[0]);
      for (int c = 0; c < 13; c++) begin
         rdy = !((c >= 3) && (c < 8));
         d   = 4'($urandom);
         a_drive(1'b0, 4'b0010, d, rdy);
         a_chk("bp_beat", 4'b0010, 2'd1, 1'b1, d[1]);
      end
      d = 4'($urandom);
      a_drive(1'b0, 4'b0010, d, 1'b1);
      a_chk("bp_release_gap", 4'b0000, 2'd1, 1'b0, d[1]);
      d = 4'($urandom);
      a_drive(1'b0, 4'b0010, d, 1'b1);
      a_chk("bp_regrant", 4'b0010, 2'd1, 1'b1, d[1]);
      a_drive(1'b0, 4'b0000, 4'b1111, 1'b1);
      a_chk("bp_drop_req", 4'b0010, 2'd1, 1'b0, 1'b1);
      a_drive(1'b0, 4'b0000, 4'b1101, 1'b1);
      a_chk("bp_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

      // N=3: reset mid-burst of requester 2, re-grant, pointer wrap to 0.
      d3 = 3'($urandom);
      b_drive(1'b0, 3'b100, d3, 1'b1);
      b_chk("odd_arbitrate", 3'b000, 2'd0, 1'b0, d3[0]);
      for (int b = 0; b < 4; b++) begin
         d3 = 3'($urandom);
         b_drive(1'b0, 3'b100, d3, 1'b1);
         b_chk("odd_beat", 3'b100, 2'd2, 1'b1, d3[2]);
      end
      d3 = 3'($urandom);
      b_drive(1'b1, 3'b100, d3, 1'b1);
      b_chk("odd_reset_cycle", 3'b100, 2'd2, 1'b1, d3[2]);
      d3 = 3'($urandom);
      b_drive(1'b0, 3'b100, d3, 1'b1);
      b_chk("odd_after_reset", 3'b000, 2'd0, 1'b0, d3[0]);
      for (int b = 0; b < 8; b++) begin
         d3 = 3'($urandom);
         b_drive(1'b0, 3'b111, d3, 1'b1);
         b_chk("odd_full_burst", 3'b100, 2'd2, 1'b1, d3[2]);
      end
      d3 = 3'($urandom);
      b_drive(1'b0, 3'b111, d3, 1'b1);
      b_chk("odd_gap", 3'b000, 2'd2, 1'b0, d3[2]);
      d3 = 3'($urandom);
      b_drive(1'b0, 3'b111, d3, 1'b1);
      b_chk("odd_ptr_wrap", 3'b001, 2'd0, 1'b1, d3[0]);

      // MAX_BURST=1: one beat per grant, alternating 0 and 1.
      d = 4'($urandom);
      c_drive(1'b0, 4'b0011, d, 1'b1);
      c_chk("mb1_arbitrate", 4'b0000, 2'd0, 1'b0, d[0]);
      for (int g = 0; g < 4; g++) begin
         o = g % 2;
         d = 4'($urandom);
         c_drive(1'b0, 4'b0011, d, 1'b1);
         c_chk("mb1_beat", 4'(1 << o), 2'(o), 1'b1, d[o]);
         d = 4'($urandom);
         c_drive(1'b0, 4'b0011, d, 1'b1);
         c_chk("mb1_gap", 4'b0000, 2'(o), 1'b0, d[o]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
